// File: rtl/div_unit.sv
// div_unit: RV32M DIV/DIVU/REM/REMU by restoring shift-subtract, one quotient bit per cycle (optional macro: DIV_SIGNED_EN).
// Latency 33 cycles (1 for divide-by-zero/overflow); start_i is dropped while busy_o, accepted during valid_o.
module div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  funct_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] res_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        rem_sel;
    logic        neg_q;
    logic        neg_r;

    logic        accept;
    logic        op1_neg, op2_neg;
    logic        div_zero, ovf, special;
    logic [31:0] mag1, mag2, special_res;
    logic [32:0] shifted, diff;
    logic [31:0] quo_nxt, rem_nxt, quo_fix, rem_fix, calc_res;
    logic        last;

    assign accept = start_i && (state != CALC);

`ifdef DIV_SIGNED_EN
    logic sgn;
    logic unused_funct;

    assign unused_funct = funct_i[2];
    assign sgn          = ~funct_i[0];
    assign op1_neg      = sgn & op1_i[31];
    assign op2_neg      = sgn & op2_i[31];
    assign ovf          = sgn && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign mag1         = op1_neg ? (32'd0 - op1_i) : op1_i;
    assign mag2         = op2_neg ? (32'd0 - op2_i) : op2_i;
`else
    logic unused_funct;

    assign unused_funct = ^{funct_i[2], funct_i[0]};
    assign op1_neg      = 1'b0;
    assign op2_neg      = 1'b0;
    assign ovf          = 1'b0;
    assign mag1         = op1_i;
    assign mag2         = op2_i;
`endif

    assign div_zero = (op2_i == 32'd0);
    assign special  = div_zero | ovf;

    always_comb begin
        special_res = 32'd0;
        if (div_zero)
            special_res = funct_i[1] ? op1_i : 32'hFFFF_FFFF;
        else
            special_res = funct_i[1] ? 32'd0 : 32'h8000_0000;
    end

    // One restoring step: bring in the next dividend bit and trial-subtract
    assign shifted  = {rem, quo[31]};
    assign diff     = shifted - {1'b0, dvs};
    assign quo_nxt  = {quo[30:0], ~diff[32]};
    assign rem_nxt  = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_fix  = neg_q ? (32'd0 - quo_nxt) : quo_nxt;
    assign rem_fix  = neg_r ? (32'd0 - rem_nxt) : rem_nxt;
    assign calc_res = rem_sel ? rem_fix : quo_fix;
    assign last     = (cnt == 6'd31);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = special ? DONE : CALC;
            end
            CALC: begin
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                if (accept)
                    state_nxt = special ? DONE : CALC;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= 6'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            dvs     <= 32'd0;
            rem_sel <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            res_o   <= 32'd0;
        end else if (accept) begin
            cnt     <= 6'd0;
            quo     <= mag1;
            rem     <= 32'd0;
            dvs     <= mag2;
            rem_sel <= funct_i[1];
            neg_q   <= op1_neg ^ op2_neg;
            neg_r   <= op1_neg;
            if (special)
                res_o <= special_res;
        end else if (state == CALC) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= last ? 6'd0 : cnt + 6'd1;
            if (last)
                res_o <= calc_res;
        end
    end

    assign busy_o  = (state == CALC);
    assign valid_o = (state == DONE);

endmodule
